// File: rtl/radix8_booth_accumulator.sv
// Accumulates radix-8 Booth partial products (LSB digit first) into a signed 2k-bit product.
// Uses an add-then-arithmetic-shift-right-by-3 accumulator so each digit adds at a fixed position.
module radix8_booth_accumulator #(
    parameter int unsigned k = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [k+2:0]   srcA,
    output logic signed [2*k-1:0] product,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned ITER = (k + 2) / 3;
    localparam int unsigned CW   = $clog2(ITER + 1);
    localparam int unsigned HW   = k + 4;
    localparam int unsigned LW   = 3 * ITER;
    localparam int unsigned AW   = HW + LW;
    localparam int unsigned PW   = 2 * k;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [AW-1:0]        r_acc;
    logic [PW-1:0]        r_product;
    logic                 r_busy;
    logic                 r_done;

    logic signed [HW:0]   w_sum;
    logic signed [AW:0]   w_cat;
    logic [AW-1:0]        w_acc_next;
    logic                 w_last;

    // The high part holds the running sum; digits shift down into the low part as they settle.
    assign w_sum = $signed({r_acc[AW-1], r_acc[AW-1:LW]})
                 + $signed({{2{srcA[k+2]}}, srcA});
    assign w_cat      = {w_sum, r_acc[LW-1:0]};
    assign w_acc_next = AW'(w_cat >>> 3);
    assign w_last     = (r_cnt == CW'(ITER - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            // Upstream is only loading operands on this edge, so srcA is not sampled.
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_state   <= S_DONE;
                r_product <= w_acc_next[PW-1:0];
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
            end
        end
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: doc/radix8_booth_accumulator.md
RADIX8_BOOTH_ACCUMULATOR -- requirements
Module: radix8_booth_accumulator

Interface
REQ-001 Parameter: k, 4, operand width in bits (multiplier x and multiplicand a, two's complement); k >= 3 SHALL be supported.
REQ-002 Derived constant: ITER = ceil(k/3), the number of radix-8 digits per multiplication.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  operation start, sampled on the same edge the upstream radix-8 partial-product stage loads its operands.
REQ-006 srcA  input  k+3  signed partial product (digit times a, range -4a..+4a) from the upstream stage, least-significant digit first.
REQ-007 product  output  2k  signed result x*a.
REQ-008 busy  output  1  high while digits are being accumulated.
REQ-009 done  output  1  high while product holds a completed result.

Function
REQ-010 FSM states SHALL be IDLE, RUN and DONE, with a digit counter of ceil(log2(ITER+1)) bits.
REQ-011 start=1 at any rising edge, in any state, SHALL clear the accumulator and counter, drive done=0, and enter RUN.
REQ-012 srcA SHALL be ignored on the edge where start=1, because the upstream stage is only loading.
REQ-013 In RUN with start=0, each edge SHALL accumulate srcA as digit number counter, weighted 8^counter, and increment the counter.
REQ-014 The edge that accumulates digit ITER-1 SHALL enter DONE.
REQ-015 After a start edge T, srcA SHALL be sampled on edges T+1..T+ITER, and done SHALL rise after edge T+ITER (2 cycles for k=4).
REQ-016 Accumulation SHALL be signed: each srcA is sign-extended, and the accumulator high part is at least k+4 bits so no intermediate overflow occurs.
REQ-017 An add-then-arithmetic-shift-right-by-3 structure SHALL be used.
REQ-018 product SHALL equal the 2k low bits of sum(srcA_i * 8^i, i=0..ITER-1).
REQ-019 product SHALL update only on the edge that enters DONE and SHALL hold in DONE and IDLE until the next completion.
REQ-020 busy SHALL equal (state==RUN), registered; done SHALL equal (state==DONE), registered.
REQ-021 DONE SHALL persist while start=0.
REQ-022 IDLE SHALL be left only on start.
REQ-023 start re-asserted during RUN SHALL abort the current operation with no done pulse and restart per REQ-011.
REQ-024 start held high for several cycles SHALL keep reloading; accumulation SHALL begin on the first edge with start=0.
REQ-025 If srcA is X/unknown outside the sampled edges, it SHALL not affect state.

Reset
REQ-026 rst=0 SHALL immediately, with no clock required, force state=IDLE, counter=0, accumulator=0, product=0, busy=0 and done=0.
REQ-027 Reset asserted mid-RUN SHALL discard the partial result.
REQ-028 After rst deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-029 The bench SHALL pair the block with the upstream radix-8 stage, both with k=4 and sharing x, a and start; k=4, x=3, a=5, one-cycle start -> busy high for 2 cycles, then done=1 and product=8'h0F.
REQ-030 k=4, x=-8, a=-8 -> product=8'h40 (64); x=-8, a=7 -> product=8'hC8 (-56); x=7, a=-1 -> product=8'hF9.
REQ-031 k=4, x=0, a=-5 -> product=8'h00 and done after 2 cycles.
REQ-032 Start x=3, a=5, then re-assert start with x=2, a=-3 one cycle later -> no done for the first operation, and final product=8'hFA.
REQ-033 Assert rst mid-RUN -> product=0, busy=0 and done=0 immediately without a clock edge; a subsequent start x=-1, a=-1 -> product=8'h01.
REQ-034 Exhaustive k=4 sweep of all 256 (x, a) pairs -> product == x*a (8-bit signed) every time, with done latency exactly 2 cycles after the start edge.
